// File: rtl/bootrom_ctrl.sv
// Boot ROM sequencer: copies ROM into SRAM while sharing the ROM read port with the CPU.
// Optional mod-256 checksum of copied bytes is built when BOOTROM_CHECKSUM_EN is defined.
module bootrom_ctrl #(
    parameter int                 SRAM_AW   = 19,
    parameter logic [SRAM_AW-1:0] DEST_BASE = '0,
    parameter int                 ROM_BYTES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [13:0]        rom_a,
    input  logic [7:0]         rom_dout,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [7:0]         sram_din,
    output logic               sram_we,
    input  logic               sram_ready,
    input  logic               cpu_req,
    input  logic [13:0]        cpu_a,
    output logic               cpu_ack,
    output logic [7:0]         cpu_dout,
    output logic               busy,
    output logic               done,
    output logic [7:0]         checksum
);
    localparam int IW = (ROM_BYTES > 1) ? $clog2(ROM_BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(ROM_BYTES - 1);

    typedef enum logic [2:0] {ARB, C_ADDR, C_WAIT, C_WR, P_ADDR, P_WAIT, P_ACK} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [13:0]   rom_a_q, rom_a_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    cpu_dout_q, cpu_dout_d;
    logic          last_cpu_q, last_cpu_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          grant_cpu;

    // CPU wins the slot unless it had the previous one and the copy still needs a turn.
    assign grant_cpu = cpu_req && (!last_cpu_q || done_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB;
            idx_q      <= '0;
            rom_a_q    <= '0;
            data_q     <= '0;
            cpu_dout_q <= '0;
            last_cpu_q <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rom_a_q    <= rom_a_d;
            data_q     <= data_d;
            cpu_dout_q <= cpu_dout_d;
            last_cpu_q <= last_cpu_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rom_a_d    = rom_a_q;
        data_d     = data_q;
        cpu_dout_d = cpu_dout_q;
        last_cpu_d = last_cpu_q;
        busy_d     = busy_q;
        done_d     = done_q;
        sram_we    = 1'b0;
        cpu_ack    = 1'b0;
        case (state_q)
            ARB: begin
                if (grant_cpu) begin
                    state_d    = P_ADDR;
                    rom_a_d    = cpu_a;
                    last_cpu_d = 1'b1;
                end else if (!done_q) begin
                    state_d    = C_ADDR;
                    rom_a_d    = 14'(idx_q);
                    last_cpu_d = 1'b0;
                end
            end
            C_ADDR: state_d = C_WAIT;
            C_WAIT: begin
                data_d  = rom_dout;
                state_d = C_WR;
            end
            C_WR: begin
                sram_we = 1'b1;
                if (sram_ready) begin
                    state_d = ARB;
                    // Index saturates at the last byte so it never wraps after done.
                    if (idx_q == LAST_IDX) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            P_ADDR: state_d = P_WAIT;
            P_WAIT: begin
                cpu_dout_d = rom_dout;
                state_d    = P_ACK;
            end
            P_ACK: begin
                cpu_ack = 1'b1;
                state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    assign rom_a    = rom_a_q;
    assign sram_a   = DEST_BASE + SRAM_AW'(idx_q);
    assign sram_din = data_q;
    assign cpu_dout = cpu_dout_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef BOOTROM_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    assign csum_d = (state_q == C_WR && sram_ready) ? csum_q + data_q : csum_q;

    always_ff @(posedge clk) begin
        if (!rst_n) csum_q <= '0;
        else        csum_q <= csum_d;
    end

    assign checksum = csum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_bootrom_ctrl.sv
// Bench for bootrom_ctrl: slot-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized SRAM stalls, CPU traffic and resets.
module tb_bootrom_ctrl;
    localparam int          AW    = 19;
    localparam logic [18:0] BASE  = 19'h7FFE0;  // forces address wrap past 2^19
    localparam int          ROM_N = 64;
`ifdef BOOTROM_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif
    localparam int SL_ARB = 0, SL_CPU = 1, SL_COPY = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [13:0]   rom_a;
    logic [7:0]    rom_dout = 8'h00;
    logic [AW-1:0] sram_a;
    logic [7:0]    sram_din;
    logic          sram_we;
    logic          sram_ready = 1'b1;
    logic          cpu_req = 1'b0;
    logic [13:0]   cpu_a = '0;
    logic          cpu_ack;
    logic [7:0]    cpu_dout;
    logic          busy, done;
    logic [7:0]    checksum;

    bootrom_ctrl #(.SRAM_AW(AW), .DEST_BASE(BASE), .ROM_BYTES(ROM_N)) dut (
        .clk(clk), .rst_n(rst_n), .rom_a(rom_a), .rom_dout(rom_dout),
        .sram_a(sram_a), .sram_din(sram_din), .sram_we(sram_we), .sram_ready(sram_ready),
        .cpu_req(cpu_req), .cpu_a(cpu_a), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [ROM_N];
    always @(posedge clk) rom_dout <= mem[rom_a[5:0]];

    int n_chk = 0, n_err = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // cycle counter: 0 is the first cycle after the reset edge
    int cyc = 0;
    always @(posedge clk) cyc <= (!rst_n) ? 0 : cyc + 1;

    int         done_cyc = -1;
    logic [18:0] wr_a[$];
    logic [7:0]  wr_d[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (sram_we && sram_ready) begin
                wr_a.push_back(sram_a);
                wr_d.push_back(sram_din);
            end
            if (done && done_cyc < 0) done_cyc = cyc;
        end
    end

    // Reference model: one slot at a time, arbitration cycle then 3+ slot cycles.
    bit          m_valid = 1'b0;
    int          m_slot, m_pos, m_k;
    bit          m_last_cpu;
    logic [13:0] m_addr, m_rom_a;
    logic [7:0]  m_cdout, m_csum;

    always @(negedge clk) begin
        logic exp_we, exp_ack;
        if (m_valid) begin
            exp_we  = (m_slot == SL_COPY) && (m_pos == 3);
            exp_ack = (m_slot == SL_CPU) && (m_pos == 3);
            if (exp_ack) m_cdout = mem[m_addr[5:0]];
            chk("m_sram_we", 32'(sram_we), 32'(exp_we));
            chk("m_cpu_ack", 32'(cpu_ack), 32'(exp_ack));
            chk("m_done", 32'(done), 32'(m_k == ROM_N));
            chk("m_busy", 32'(busy), 32'(m_k != ROM_N));
            chk("m_rom_a", 32'(rom_a), 32'(m_rom_a));
            chk("m_cpu_dout", 32'(cpu_dout), 32'(m_cdout));
            chk("m_checksum", 32'(checksum), CSUM_ON ? 32'(m_csum) : 32'h0);
            if (exp_we) begin
                chk("m_sram_a", 32'(sram_a), 32'(19'(BASE + 19'(m_k))));
                chk("m_sram_din", 32'(sram_din), 32'(mem[m_k[5:0]]));
            end
        end
        if (!rst_n) begin
            m_valid = 1'b1; m_slot = SL_ARB; m_pos = 0; m_k = 0; m_last_cpu = 1'b0;
            m_addr = '0; m_rom_a = '0; m_cdout = '0; m_csum = '0;
        end else if (m_valid) begin
            case (m_slot)
                SL_ARB: begin
                    if (cpu_req && !m_last_cpu) begin
                        m_slot = SL_CPU; m_pos = 1; m_addr = cpu_a; m_rom_a = cpu_a; m_last_cpu = 1'b1;
                    end else if (m_k < ROM_N) begin
                        m_slot = SL_COPY; m_pos = 1; m_rom_a = 14'(m_k); m_last_cpu = 1'b0;
                    end else if (cpu_req) begin
                        m_slot = SL_CPU; m_pos = 1; m_addr = cpu_a; m_rom_a = cpu_a; m_last_cpu = 1'b1;
                    end
                end
                SL_CPU: if (m_pos == 3) m_slot = SL_ARB; else m_pos++;
                default: begin
                    if (m_pos < 3) m_pos++;
                    else if (sram_ready) begin
                        m_csum = m_csum + mem[m_k[5:0]];
                        m_k++;
                        m_slot = SL_ARB;
                    end
                end
            endcase
        end
    end

    task automatic do_reset(input bit rnd_mem);
        rst_n = 1'b0;
        done_cyc = -1;
        wr_a.delete();
        wr_d.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        if (rnd_mem) foreach (mem[i]) mem[i] = 8'($urandom);
        chk("rst_sram_we", 32'(sram_we), 32'h0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_rom_a", 32'(rom_a), 32'h0);
        chk("rst_sram_a", 32'(sram_a), 32'(BASE));
        chk("rst_sram_din", 32'(sram_din), 32'h0);
        chk("rst_cpu_dout", 32'(cpu_dout), 32'h0);
        chk("rst_checksum", 32'(checksum), 32'h0);
    endtask

    task automatic wait_done(input string nm, input int budget);
        for (int c = 0; c < budget && done_cyc < 0; c++) begin
            @(posedge clk); #1;
        end
        if (done_cyc < 0) chk({nm, "_timeout"}, 32'h0, 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        int  acks, n0, lat, cnt10, stall;
        bit  seen;
        logic [18:0] sa;
        logic [7:0]  sd;

        foreach (mem[i]) mem[i] = 8'(i + 1);

        // plain copy, SRAM always ready
        do_reset(1'b0);
        wait_done("p1", 400);
        chk("p1_done_cyc", done_cyc, 256);
        chk("p1_nwr", wr_a.size(), 64);
        if (wr_a.size() >= 64) begin
            chk("p1_wr0_a", 32'(wr_a[0]), 32'(BASE));
            chk("p1_wr0_d", 32'(wr_d[0]), 32'h01);
            chk("p1_wr63_a", 32'(wr_a[63]), 32'h1F);
            chk("p1_wr63_d", 32'(wr_d[63]), 32'h40);
        end
        chk("p1_checksum", 32'(checksum), CSUM_ON ? 32'h20 : 32'h00);

        // 5-cycle SRAM stall on byte 10
        do_reset(1'b0);
        seen = 1'b0; stall = 0; sa = '0; sd = '0;
        for (int c = 0; c < 400 && done_cyc < 0; c++) begin
            @(posedge clk); #1;
            if (stall > 0) begin
                chk("p2_we_held", 32'(sram_we), 32'h1);
                chk("p2_a_held", 32'(sram_a), 32'(sa));
                chk("p2_din_held", 32'(sram_din), 32'(sd));
                stall--;
                if (stall == 0) sram_ready = 1'b1;
            end else if (!seen && sram_we && sram_a == 19'(BASE + 19'd10)) begin
                seen = 1'b1; sa = sram_a; sd = sram_din; sram_ready = 1'b0; stall = 5;
            end
        end
        if (done_cyc < 0) chk("p2_timeout", 32'h0, 32'h1);
        chk("p2_done_cyc", done_cyc, 261);
        cnt10 = 0;
        foreach (wr_a[i]) if (wr_a[i] == 19'(BASE + 19'd10)) begin
            cnt10++;
            chk("p2_b10_data", 32'(wr_d[i]), 32'h0B);
        end
        chk("p2_b10_writes", cnt10, 1);
        sram_ready = 1'b1;

        // CPU hammering address 3 from reset
        do_reset(1'b0);
        cpu_req = 1'b1; cpu_a = 14'd3;
        acks = 0;
        for (int c = 0; c < 700 && done_cyc < 0; c++) begin
            @(posedge clk); #1;
            if (cpu_ack && done_cyc < 0) begin
                acks++;
                chk("p3_ack_data", 32'(cpu_dout), 32'h04);
            end
        end
        if (done_cyc < 0) chk("p3_timeout", 32'h0, 32'h1);
        chk("p3_done_cyc", done_cyc, 512);
        chk("p3_acks", acks, 64);
        cpu_req = 1'b0;
        repeat (6) begin @(posedge clk); #1; end

        // CPU read after done
        n0 = wr_a.size();
        cpu_req = 1'b1; cpu_a = 14'd63;
        lat = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            lat++;
            if (cpu_ack) break;
        end
        cpu_req = 1'b0;
        chk("p4_ack", 32'(cpu_ack), 32'h1);
        chk("p4_latency", lat, 3);
        chk("p4_dout", 32'(cpu_dout), 32'h40);
        repeat (8) begin @(posedge clk); #1; end
        chk("p4_no_writes", wr_a.size(), n0);

        // reset during byte 30's write
        do_reset(1'b0);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk); #1;
            if (sram_we && sram_a == 19'(BASE + 19'd30)) seen = 1'b1;
        end
        chk("p5_reached_b30", 32'(seen), 32'h1);
        sram_ready = 1'b0;
        do_reset(1'b0);
        sram_ready = 1'b1;
        wait_done("p5", 400);
        chk("p5_done_cyc", done_cyc, 256);
        chk("p5_nwr", wr_a.size(), 64);
        if (wr_a.size() > 0) begin
            chk("p5_first_a", 32'(wr_a[0]), 32'(BASE));
            chk("p5_first_d", 32'(wr_d[0]), 32'h01);
        end

        // randomized traffic, stalls, ROM contents and resets
        do_reset(1'b1);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            sram_ready = ($urandom_range(0, 3) != 0);
            if (cpu_ack) begin
                if ($urandom_range(0, 1) == 1) cpu_a = 14'($urandom);
                else cpu_req = 1'b0;
            end else if (!cpu_req && $urandom_range(0, 3) == 0) begin
                cpu_req = 1'b1;
                cpu_a = 14'($urandom);
            end
            if ($urandom_range(0, 599) == 0) do_reset(1'b1);
        end
        cpu_req = 1'b0;
        sram_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
